// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MDR / memory interface slice.
//   DATA_W      : default data / bus width
//   ADDR_W      : default memory address width
//   mdr_state_t : transaction state of the MDR controller (IDLE, READ, WRITE)
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mdr_state_t;

endpackage

// File: rtl/mdr_mem_interface_if.sv
// ---------------------------------------------------------------------------
// mdr_mem_interface_if
// Memory-side handshake bundle between the MDR controller and the memory.
//   mem_addr     : word address latched from MAR       (master -> slave)
//   mem_data_out : store data, equals MDR during writes (master -> slave)
//   mem_rd       : read strobe, held until mem_ready    (master -> slave)
//   mem_wr       : write strobe, held until mem_ready   (master -> slave)
//   mem_data_in  : read return data                     (slave -> master)
//   mem_ready    : transfer completion                  (slave -> master)
// Modports: master (controller side), slave (memory side).
// ---------------------------------------------------------------------------
interface mdr_mem_interface_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_data_out,
        output mem_rd,
        output mem_wr,
        input  mem_data_in,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_data_out,
        input  mem_rd,
        input  mem_wr,
        output mem_data_in,
        output mem_ready
    );

endinterface

// File: rtl/mdr_timeout_counter.sv
// ---------------------------------------------------------------------------
// mdr_timeout_counter
// Watchdog for a pending memory transfer. Only built when the macro
// MDR_TIMEOUT_EN is defined; otherwise this file compiles to nothing so no
// counter logic exists in the default build.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   start   : a READ/WRITE transaction is being accepted this cycle
//   active  : a transaction is in flight (controller busy)
//   expired : the current busy cycle is cycle number TIMEOUT_CYCLES
// Down-counter: loaded with TIMEOUT_CYCLES-1 on start, so terminal count
// (zero) is reached in the TIMEOUT_CYCLES-th busy cycle.
// ---------------------------------------------------------------------------
`ifdef MDR_TIMEOUT_EN
module mdr_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic active,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start) begin
            count <= LOAD_VAL;
        end else if (active && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = active && (count == '0);

endmodule
`endif

// File: rtl/mdr_mem_interface.sv
// ---------------------------------------------------------------------------
// mdr_mem_interface
// Memory Data Register and its memory handshake controller.
// The MDR is loaded either from the shared bus or from memory; its contents
// drive the bus multiplexer and are the store data for memory writes.
//
// Parameters:
//   DATA_W         : data / bus width
//   ADDR_W         : memory address width
//   TIMEOUT_CYCLES : maximum busy cycles waiting for mem_ready
//                    (effective only when MDR_TIMEOUT_EN is defined)
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus_mux_out    : shared bus value, MDR source for bus loads
//   mdr_in         : MDR load enable (bus, or memory when read=1)
//   read / write   : memory read / write request
//   mar_addr       : address from MAR, latched when a transfer starts
//   memBus         : memory handshake (mdr_mem_interface_if.master)
//   mdr_out        : MDR contents
//   busy           : 1 while a READ or WRITE is in flight
//   done           : one-cycle pulse in the first IDLE cycle after a
//                    completed transfer
//   timeout_err    : sticky timeout flag, cleared by the next accepted command
// Optional feature macro: MDR_TIMEOUT_EN (abandon transfers that see no
// mem_ready within TIMEOUT_CYCLES busy cycles). Without it the controller
// waits forever and timeout_err is tied low.
//
// state | meaning
// IDLE  | accepts bus load / read / write commands
// READ  | mem_rd asserted, waiting for mem_ready to capture mem_data_in
// WRITE | mem_wr asserted with MDR on mem_data_out, waiting for mem_ready
// ---------------------------------------------------------------------------
module mdr_mem_interface #(
    parameter int DATA_W         = cpu_pkg::DATA_W,
    parameter int ADDR_W         = cpu_pkg::ADDR_W,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] bus_mux_out,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] mar_addr,
    mdr_mem_interface_if.master memBus,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    import cpu_pkg::*;

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("mdr_mem_interface: TIMEOUT_CYCLES must be at least 1");
    end

    mdr_state_t        state;
    logic [DATA_W-1:0] mdrReg;

    // Read outranks write whenever it is asserted, even without mdr_in;
    // a bus load needs both request lines low.
    logic readCmd;
    logic writeCmd;
    logic loadCmd;

    assign readCmd  = read && mdr_in;
    assign writeCmd = write && !read;
    assign loadCmd  = mdr_in && !read && !write;

    assign mdr_out = mdrReg;

`ifdef MDR_TIMEOUT_EN
    logic txnStart;
    logic timeoutHit;

    assign txnStart = (state == IDLE) && (readCmd || writeCmd);

    mdr_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) uTimeoutCounter (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (txnStart),
        .active  (busy),
        .expired (timeoutHit)
    );
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            mdrReg              <= '0;
            memBus.mem_addr     <= '0;
            memBus.mem_data_out <= '0;
            memBus.mem_rd       <= 1'b0;
            memBus.mem_wr       <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            timeout_err         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (readCmd) begin
                        state           <= READ;
                        memBus.mem_addr <= mar_addr;
                        memBus.mem_rd   <= 1'b1;
                        busy            <= 1'b1;
                    end else if (writeCmd) begin
                        state               <= WRITE;
                        memBus.mem_addr     <= mar_addr;
                        memBus.mem_data_out <= mdrReg;
                        memBus.mem_wr       <= 1'b1;
                        busy                <= 1'b1;
                    end else if (loadCmd) begin
                        mdrReg <= bus_mux_out;
                    end
`ifdef MDR_TIMEOUT_EN
                    if (readCmd || writeCmd || loadCmd) begin
                        timeout_err <= 1'b0;
                    end
`endif
                end

                READ: begin
                    // mem_ready wins over a timeout landing on the same edge.
                    if (memBus.mem_ready) begin
                        mdrReg        <= memBus.mem_data_in;
                        state         <= IDLE;
                        memBus.mem_rd <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end
`ifdef MDR_TIMEOUT_EN
                    else if (timeoutHit) begin
                        state         <= IDLE;
                        memBus.mem_rd <= 1'b0;
                        busy          <= 1'b0;
                        timeout_err   <= 1'b1;
                    end
`endif
                end

                WRITE: begin
                    if (memBus.mem_ready) begin
                        state               <= IDLE;
                        memBus.mem_wr       <= 1'b0;
                        memBus.mem_data_out <= '0;
                        busy                <= 1'b0;
                        done                <= 1'b1;
                    end
`ifdef MDR_TIMEOUT_EN
                    else if (timeoutHit) begin
                        state               <= IDLE;
                        memBus.mem_wr       <= 1'b0;
                        memBus.mem_data_out <= '0;
                        busy                <= 1'b0;
                        timeout_err         <= 1'b1;
                    end
`endif
                end

                default: begin
                    state         <= IDLE;
                    memBus.mem_rd <= 1'b0;
                    memBus.mem_wr <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_mem_interface.sv
// ---------------------------------------------------------------------------
// tb_mdr_mem_interface
// Self-checking bench for mdr_mem_interface. The bench plays the memory
// (drives mem_data_in / mem_ready) and keeps a transaction-level model:
// the expected MDR value, the expected sticky error flag, and the rules
// "busy for exactly the latency cycles", "one done pulse afterwards".
// Inputs are driven and outputs sampled on the falling clock edge.
// The timeout section is only built when MDR_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_mdr_mem_interface;

    localparam int DW      = 32;
    localparam int AW      = 9;
    localparam int TIMEOUT = 15;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [DW-1:0] bus_mux_out;
    logic          mdr_in;
    logic          read;
    logic          write;
    logic [AW-1:0] mar_addr;
    logic [DW-1:0] mdr_out;
    logic          busy;
    logic          done;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] refMdr = '0;
    logic          refErr = 1'b0;

    always #5 clock = ~clock;

    mdr_mem_interface_if #(.DATA_W(DW), .ADDR_W(AW)) memIf ();

    mdr_mem_interface #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus_mux_out (bus_mux_out),
        .mdr_in      (mdr_in),
        .read        (read),
        .write       (write),
        .mar_addr    (mar_addr),
        .memBus      (memIf),
        .mdr_out     (mdr_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        read            = 1'b0;
        write           = 1'b0;
        mdr_in          = 1'b0;
        memIf.mem_ready = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_mdr"},    mdr_out,                  32'd0);
        check({tag, "_addr"},   32'(memIf.mem_addr),      32'd0);
        check({tag, "_wdata"},  memIf.mem_data_out,       32'd0);
        check({tag, "_rd"},     32'(memIf.mem_rd),        32'd0);
        check({tag, "_wr"},     32'(memIf.mem_wr),        32'd0);
        check({tag, "_busy"},   32'(busy),                32'd0);
        check({tag, "_done"},   32'(done),                32'd0);
        check({tag, "_terr"},   32'(timeout_err),         32'd0);
    endtask

    // Called at a falling edge; returns at a falling edge with inputs idle.
    task automatic doLoad(input logic [DW-1:0] val);
        bus_mux_out = val;
        mdr_in      = 1'b1;
        read        = 1'b0;
        write       = 1'b0;
        @(negedge clock);
        idleInputs();
        refMdr = val;
        refErr = 1'b0;
        check("load_mdr",  mdr_out,           refMdr);
        check("load_done", 32'(done),         32'd0);
        check("load_busy", 32'(busy),         32'd0);
        check("load_terr", 32'(timeout_err),  32'(refErr));
    endtask

    // While busy with noisy=1 the bench keeps issuing a read (plus random
    // write/address/bus traffic) that must be ignored.
    task automatic busyNoise(input bit noisy);
        if (noisy) begin
            read        = 1'b1;
            mdr_in      = 1'b1;
            write       = 1'($urandom);
            mar_addr    = AW'($urandom);
            bus_mux_out = $urandom;
        end else begin
            read   = 1'b0;
            write  = 1'b0;
            mdr_in = 1'b0;
        end
    endtask

    task automatic doRead(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int lat, input bit noisy, input bit alsoWrite);
        read     = 1'b1;
        mdr_in   = 1'b1;
        write    = alsoWrite;
        mar_addr = addr;
        refErr   = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            check("rd_busy",  32'(busy),           32'd1);
            check("rd_rd",    32'(memIf.mem_rd),   32'd1);
            check("rd_wr",    32'(memIf.mem_wr),   32'd0);
            check("rd_addr",  32'(memIf.mem_addr), 32'(addr));
            check("rd_done",  32'(done),           32'd0);
            check("rd_hold",  mdr_out,             refMdr);
            check("rd_terr",  32'(timeout_err),    32'd0);
            busyNoise(noisy);
            memIf.mem_ready   = (k == lat);
            memIf.mem_data_in = (k == lat) ? data : $urandom;
        end
        @(negedge clock);
        idleInputs();
        refMdr = data;
        check("rd_end_busy", 32'(busy),         32'd0);
        check("rd_end_rd",   32'(memIf.mem_rd), 32'd0);
        check("rd_end_done", 32'(done),         32'd1);
        check("rd_end_mdr",  mdr_out,           refMdr);
        @(negedge clock);
        check("rd_post_done", 32'(done),        32'd0);
        check("rd_post_busy", 32'(busy),        32'd0);
        check("rd_post_wr",   32'(memIf.mem_wr), 32'd0);
    endtask

    task automatic doWrite(input logic [AW-1:0] addr, input int lat, input bit noisy);
        write       = 1'b1;
        read        = 1'b0;
        mdr_in      = 1'($urandom);
        bus_mux_out = $urandom;
        mar_addr    = addr;
        refErr      = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            check("wr_busy",  32'(busy),           32'd1);
            check("wr_wr",    32'(memIf.mem_wr),   32'd1);
            check("wr_rd",    32'(memIf.mem_rd),   32'd0);
            check("wr_addr",  32'(memIf.mem_addr), 32'(addr));
            check("wr_data",  memIf.mem_data_out,  refMdr);
            check("wr_done",  32'(done),           32'd0);
            check("wr_terr",  32'(timeout_err),    32'd0);
            busyNoise(noisy);
            memIf.mem_ready   = (k == lat);
            memIf.mem_data_in = $urandom;
        end
        @(negedge clock);
        idleInputs();
        check("wr_end_busy", 32'(busy),         32'd0);
        check("wr_end_wr",   32'(memIf.mem_wr), 32'd0);
        check("wr_end_done", 32'(done),         32'd1);
        check("wr_end_mdr",  mdr_out,           refMdr);
        @(negedge clock);
        check("wr_post_done", 32'(done),        32'd0);
    endtask

    task automatic strayReady();
        memIf.mem_ready   = 1'b1;
        memIf.mem_data_in = $urandom;
        bus_mux_out       = $urandom;
        @(negedge clock);
        memIf.mem_ready = 1'b0;
        check("stray_mdr",  mdr_out,   refMdr);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_done", 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op;
        reset_n           = 1'b0;
        bus_mux_out       = '0;
        mar_addr          = '0;
        memIf.mem_data_in = '0;
        idleInputs();
        repeat (3) @(negedge clock);
        checkAllZero("reset");
        reset_n = 1'b1;
        @(negedge clock);
        checkAllZero("post_reset");

        // Bus load
        doLoad(32'h0000_00A5);

        // Read with ready on the third busy cycle
        doRead(9'h054, 32'h1234_5678, 3, 1'b0, 1'b0);

        // Write of a bus-loaded value, ready after one cycle
        doLoad(32'hDEAD_BEEF);
        doWrite(9'h1FF, 1, 1'b0);

        // read+write together, then a read attempt while busy
        doRead(9'h0C3, 32'hCAFE_0001, 4, 1'b1, 1'b1);

        // Stray mem_ready in IDLE
        strayReady();

        // Reset during the second READ cycle
        doLoad(32'h0BAD_F00D);
        read     = 1'b1;
        mdr_in   = 1'b1;
        mar_addr = 9'h0AA;
        @(negedge clock);
        idleInputs();
        @(negedge clock);
        check("rst_mid_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        refMdr = '0;
        refErr = 1'b0;
        checkAllZero("rst_async");
        @(negedge clock);
        reset_n           = 1'b1;
        memIf.mem_ready   = 1'b1;
        memIf.mem_data_in = 32'h5555_AAAA;
        @(negedge clock);
        memIf.mem_ready = 1'b0;
        check("rst_late_mdr",  mdr_out,           32'd0);
        check("rst_late_done", 32'(done),         32'd0);
        check("rst_late_busy", 32'(busy),         32'd0);
        check("rst_late_rd",   32'(memIf.mem_rd), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: doLoad($urandom);
                1: doRead(AW'($urandom), $urandom, int'($urandom_range(1, 5)),
                          1'($urandom), 1'($urandom));
                2: doWrite(AW'($urandom), int'($urandom_range(1, 5)), 1'($urandom));
                default: strayReady();
            endcase
        end

`ifdef MDR_TIMEOUT_EN
        // Read that never completes: abandoned after TIMEOUT busy cycles
        read     = 1'b1;
        mdr_in   = 1'b1;
        mar_addr = 9'h011;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clock);
            idleInputs();
            check("to_busy", 32'(busy), 32'd1);
        end
        @(negedge clock);
        refErr = 1'b1;
        check("to_busy_end", 32'(busy),         32'd0);
        check("to_err",      32'(timeout_err),  32'(refErr));
        check("to_done",     32'(done),         32'd0);
        check("to_mdr",      mdr_out,           refMdr);
        check("to_rd",       32'(memIf.mem_rd), 32'd0);
        @(negedge clock);
        check("to_done2",    32'(done),         32'd0);
        check("to_sticky",   32'(timeout_err),  32'd1);
        doWrite(9'h100, 2, 1'b0);
        check("to_cleared",  32'(timeout_err),  32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
